// File: rtl/gpu_sm_copyvc_mem_pkg.sv
// gpu_sm_copyvc_mem_pkg: shared GPU types and constants for the VRAM-to-CPU copy engine
package gpu_sm_copyvc_mem_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, EMIT, FLUSH} copyVcState_t;
  localparam int VRAM_WIDTH = 1024;
  localparam int VRAM_HEIGHT = 512;
  localparam int VRAM_BLOCK_PIX = 16;
  localparam logic [1:0] CMD_8B = 2'd0;
  localparam logic [1:0] CMD_32B = 2'd1;
endpackage

// File: rtl/gpu_vc_pixel_packer.sv
// gpu_vc_pixel_packer: pairs 16-bit pixels into 32-bit FIFO words, stalls on FIFO full, pads a trailing odd pixel
// Ports: i_clk, i_rst (async, active-high); i_clear restarts pairing; i_pixValid/i_pix offer a pixel;
// i_flush requests the pad push; i_fifoFull stalls; o_canAccept says the offered pixel is taken this cycle;
// o_pairHalf flags a held low pixel; o_write/o_data drive the output FIFO ({newer, older}).
module gpu_vc_pixel_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_pixValid,
  input  logic [15:0] i_pix,
  input  logic        i_flush,
  input  logic        i_fifoFull,
  output logic        o_canAccept,
  output logic        o_pairHalf,
  output logic        o_write,
  output logic [31:0] o_data
);
  logic pairHalf;
  logic [15:0] lo;
  assign o_pairHalf = pairHalf;
  assign o_canAccept = !pairHalf || !i_fifoFull;
  assign o_write = pairHalf && !i_fifoFull && (i_pixValid || i_flush);
  assign o_data = i_flush ? {16'h0000, lo} : {i_pix, lo};
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pairHalf <= 1'b0;
      lo <= '0;
    end else if (i_clear) begin
      pairHalf <= 1'b0;
    end else if (i_pixValid && o_canAccept) begin
      pairHalf <= !pairHalf;
      if (!pairHalf) lo <= i_pix;
    end else if (i_flush && o_write) begin
      pairHalf <= 1'b0;
    end
  end
endmodule

// File: rtl/gpu_sm_copyvc_mem.sv
// gpu_sm_copyvc_mem: VRAM-to-CPU copy engine reading 32-byte blocks and streaming pixel pairs to GPUREAD
// Ports: i_clk, i_rst (async, active-high); i_activateCopyVC start pulse; o_active / o_CopyInactiveNextCycle status;
// RegX0/RegY0/RegSizeW/RegSizeH rectangle; o_command/i_busy/o_commandSize/o_write/o_adr/o_subadr DDR command;
// i_dataIn/i_dataInValid read return; i_outFifoFull/o_outFifoWrite/o_outFifoData output FIFO.
// Optional macro GPU_COPYVC_PREFETCH_EN: second block buffer, next read issued during EMIT.
module gpu_sm_copyvc_mem
  import gpu_sm_copyvc_mem_pkg::*;
#(
  parameter int ADR_W = 15,
  parameter int BLOCK_PIX = VRAM_BLOCK_PIX
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_activateCopyVC,
  output logic             o_CopyInactiveNextCycle,
  output logic             o_active,
  input  logic [11:0]      RegX0,
  input  logic [11:0]      RegY0,
  input  logic [10:0]      RegSizeW,
  input  logic [9:0]       RegSizeH,
  output logic             o_command,
  input  logic             i_busy,
  output logic [1:0]       o_commandSize,
  output logic             o_write,
  output logic [ADR_W-1:0] o_adr,
  output logic [2:0]       o_subadr,
  input  logic [255:0]     i_dataIn,
  input  logic             i_dataInValid,
  input  logic             i_outFifoFull,
  output logic             o_outFifoWrite,
  output logic [31:0]      o_outFifoData
);
  copyVcState_t state, nextState;
  logic [9:0] x0, cx, nextCx, rowsLeft;
  logic [8:0] cy;
  logic [10:0] w, rowLeft, wEff;
  logic [9:0] hEff;
  logic [3:0] idx;
  logic [255:0] blk;
  logic [15:0] pix;
  logic canAccept, pairHalf, adv, rowDone, lastRow, blkDone, blockEnd, flushDone, loadNext, toWait;
  logic unusedBits;
  assign unusedBits = ^{RegX0[11:10], RegY0[11:9]};
  assign wEff = RegSizeW == 11'd0 ? 11'(VRAM_WIDTH) : RegSizeW;
  assign hEff = RegSizeH == 10'd0 ? 10'(VRAM_HEIGHT) : RegSizeH;
  assign pix = blk[{idx, 4'b0000} +: 16];
  assign adv = state == EMIT && canAccept;
  assign rowDone = rowLeft == 11'd1;
  assign lastRow = rowsLeft == 10'd1;
  assign blkDone = idx == 4'(BLOCK_PIX - 1);
  // a block ends at its last pixel or at a row end that is not the final row
  assign blockEnd = adv && (rowDone ? !lastRow : blkDone);
  assign nextCx = rowDone ? x0 : cx + 10'd1;
  assign flushDone = !pairHalf || !i_outFifoFull;
  assign o_active = state != IDLE;
  assign o_CopyInactiveNextCycle = state == FLUSH && flushDone;
  assign o_commandSize = CMD_32B;
  assign o_write = 1'b0;
  assign o_subadr = 3'd0;
`ifdef GPU_COPYVC_PREFETCH_EN
  logic [255:0] nxt;
  logic pfIssued, pfValid, pfPending, pfReady, rowEndHere, hasNext, cmdAccept;
  logic [14:0] pfAdr;
  // the rest of the current row fits inside this block
  assign rowEndHere = rowLeft <= 11'(BLOCK_PIX) - 11'(idx);
  assign hasNext = !(rowEndHere && lastRow);
  assign pfAdr = rowEndHere ? {cy + 9'd1, x0[9:4]} : {cy, cx[9:4] + 6'd1};
  assign o_command = state == REQ || (state == EMIT && hasNext && !pfIssued);
  assign o_adr = ADR_W'(state == EMIT ? pfAdr : {cy, cx[9:4]});
  assign cmdAccept = o_command && !i_busy;
  assign pfPending = pfIssued || (state == EMIT && cmdAccept);
  assign pfReady = pfValid || (pfPending && i_dataInValid);
  assign loadNext = blockEnd && pfReady;
  assign toWait = pfPending;
`else
  assign o_command = state == REQ;
  assign o_adr = ADR_W'({cy, cx[9:4]});
  assign loadNext = 1'b0;
  assign toWait = 1'b0;
`endif
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else state <= nextState;
  end
  always_comb begin
    nextState = state;
    case (state)
      IDLE: nextState = i_activateCopyVC ? REQ : IDLE;
      REQ: nextState = i_busy ? REQ : WAIT;
      WAIT: nextState = i_dataInValid ? EMIT : WAIT;
      EMIT:
        if (adv && rowDone && lastRow) nextState = FLUSH;
        else if (blockEnd) nextState = loadNext ? EMIT : (toWait ? WAIT : REQ);
      FLUSH: nextState = flushDone ? IDLE : FLUSH;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x0 <= '0;
      w <= '0;
      cx <= '0;
      cy <= '0;
      rowLeft <= '0;
      rowsLeft <= '0;
      idx <= '0;
      blk <= '0;
`ifdef GPU_COPYVC_PREFETCH_EN
      nxt <= '0;
      pfIssued <= 1'b0;
      pfValid <= 1'b0;
`endif
    end else begin
      if (state == IDLE && i_activateCopyVC) begin
        x0 <= RegX0[9:0];
        w <= wEff;
        cx <= RegX0[9:0];
        cy <= RegY0[8:0];
        rowLeft <= wEff;
        rowsLeft <= hEff;
      end
      if (state == WAIT && i_dataInValid) begin
        blk <= i_dataIn;
        idx <= cx[3:0];
      end
      if (adv) begin
        cx <= nextCx;
        idx <= idx + 4'd1;
        rowLeft <= rowDone ? w : rowLeft - 11'd1;
        if (rowDone) begin
          cy <= cy + 9'd1;
          rowsLeft <= rowsLeft - 10'd1;
        end
      end
`ifdef GPU_COPYVC_PREFETCH_EN
      if (loadNext) begin
        blk <= pfValid ? nxt : i_dataIn;
        idx <= nextCx[3:0];
      end
      if (blockEnd) begin
        pfIssued <= 1'b0;
        pfValid <= 1'b0;
      end else if (state == EMIT) begin
        if (cmdAccept) pfIssued <= 1'b1;
        if (pfPending && !pfValid && i_dataInValid) begin
          nxt <= i_dataIn;
          pfValid <= 1'b1;
        end
      end
`endif
    end
  end
  gpu_vc_pixel_packer packer (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clear(state == IDLE && i_activateCopyVC),
    .i_pixValid(state == EMIT),
    .i_pix(pix),
    .i_flush(state == FLUSH),
    .i_fifoFull(i_outFifoFull),
    .o_canAccept(canAccept),
    .o_pairHalf(pairHalf),
    .o_write(o_outFifoWrite),
    .o_data(o_outFifoData)
  );
endmodule

// File: tb/tb_gpu_sm_copyvc_mem.sv
// tb_gpu_sm_copyvc_mem: scoreboard bench for the VRAM-to-CPU copy engine
module tb_gpu_sm_copyvc_mem;
  logic i_clk = 1'b0, i_rst = 1'b1, i_activateCopyVC = 1'b0;
  logic o_CopyInactiveNextCycle, o_active, o_command, o_write, o_outFifoWrite;
  logic [11:0] RegX0 = '0, RegY0 = '0;
  logic [10:0] RegSizeW = '0;
  logic [9:0] RegSizeH = '0;
  logic i_busy = 1'b0, i_dataInValid = 1'b0, i_outFifoFull = 1'b0;
  logic [1:0] o_commandSize;
  logic [14:0] o_adr;
  logic [2:0] o_subadr;
  logic [255:0] i_dataIn = '0;
  logic [31:0] o_outFifoData;
  int nChecks = 0, nFails = 0, cyc = 0, memLat = 1;
  int pushCnt = 0, inactCnt = 0, firstPush = -1, lastPush = -1;
  logic [31:0] expData[$];
  logic [14:0] expAdr[$];

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  gpu_sm_copyvc_mem dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_activateCopyVC(i_activateCopyVC),
    .o_CopyInactiveNextCycle(o_CopyInactiveNextCycle), .o_active(o_active),
    .RegX0(RegX0), .RegY0(RegY0), .RegSizeW(RegSizeW), .RegSizeH(RegSizeH),
    .o_command(o_command), .i_busy(i_busy), .o_commandSize(o_commandSize),
    .o_write(o_write), .o_adr(o_adr), .o_subadr(o_subadr),
    .i_dataIn(i_dataIn), .i_dataInValid(i_dataInValid),
    .i_outFifoFull(i_outFifoFull), .o_outFifoWrite(o_outFifoWrite), .o_outFifoData(o_outFifoData)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input logic [31:0] act);
    nChecks++;
    nFails++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  function automatic logic [15:0] pv(input int x, input int y);
    return {6'(y), 10'(x)};
  endfunction

  task automatic modelPush(input int x0, input int y0, input int w, input int h);
    logic [15:0] lo = '0, p;
    bit half = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        int x = (x0 + c) % 1024, y = (y0 + r) % 512;
        if (c == 0 || x % 16 == 0) expAdr.push_back(15'(y * 64 + x / 16));
        p = pv(x, y);
        if (half) expData.push_back({p, lo});
        else lo = p;
        half = !half;
      end
    if (half) expData.push_back({16'h0000, lo});
  endtask

  // monitor: compares every push and every accepted command against the scoreboard
  initial begin
    bit prevInact = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        if (o_outFifoWrite) begin
          check("pushWhileFull", {31'd0, i_outFifoFull}, 32'd0);
          if (expData.size() == 0) failNow("unexpectedPush", o_outFifoData);
          else check("pushData", o_outFifoData, expData.pop_front());
          pushCnt++;
          if (firstPush < 0) firstPush = cyc;
          lastPush = cyc;
        end
        if (o_command && !i_busy) begin
          if (expAdr.size() == 0) failNow("unexpectedCmd", {17'd0, o_adr});
          else check("cmdAdr", {17'd0, o_adr}, {17'd0, expAdr.pop_front()});
        end
        if (prevInact) check("activeAfterInactNext", {31'd0, o_active}, 32'd0);
        prevInact = o_CopyInactiveNextCycle;
        if (o_CopyInactiveNextCycle) inactCnt++;
      end
    end
  end

  // memory model: in-order reads returning pixel pv(x,y) after memLat cycles
  initial begin
    logic [14:0] q[$];
    int due[$];
    bit acc;
    logic [14:0] a, fa;
    forever begin
      @(negedge i_clk);
      acc = o_command && !i_busy && !i_rst;
      a = o_adr;
      @(posedge i_clk);
      #1;
      if (acc) begin
        q.push_back(a);
        due.push_back(cyc + memLat);
      end
      i_dataInValid = 1'b0;
      if (q.size() > 0 && due[0] <= cyc) begin
        fa = q.pop_front();
        void'(due.pop_front());
        for (int k = 0; k < 16; k++) i_dataIn[16*k +: 16] = pv({fa[5:0], 4'(k)}, int'(fa[14:6]));
        i_dataInValid = 1'b1;
      end
    end
  end

  task automatic start(input int x, input int y, input int w, input int h);
    @(posedge i_clk);
    #1;
    RegX0 = 12'(x);
    RegY0 = 12'(y);
    RegSizeW = 11'(w);
    RegSizeH = 10'(h);
    i_activateCopyVC = 1'b1;
    @(posedge i_clk);
    #1;
    i_activateCopyVC = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (!o_active && n < 100) begin @(negedge i_clk); n++; end
    while (o_active && n < 5000) begin @(negedge i_clk); n++; end
    if (o_active || n >= 100 && n < 101) failNow("doneTimeout", n);
    repeat (3) @(posedge i_clk);
    #1;
    check("dataQueueEmpty", expData.size(), 0);
    check("adrQueueEmpty", expAdr.size(), 0);
    check("inactPulses", inactCnt, 1);
    inactCnt = 0;
  endtask

  initial begin
    logic [31:0] t2d[8] = '{32'hFFFDFFFC, 32'hFFFFFFFE, 32'hFC01FC00, 32'hFC03FC02,
                            32'h03FD03FC, 32'h03FF03FE, 32'h00010000, 32'h00030002};
    logic [14:0] t2a[4] = '{15'h7FFF, 15'h7FC0, 15'h003F, 15'h0000};
    int snap;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rstActive", {31'd0, o_active}, 0);
    check("rstCommand", {31'd0, o_command}, 0);
    check("rstCmdSize", {30'd0, o_commandSize}, 1);
    check("rstWrite", {31'd0, o_write}, 0);
    check("rstAdr", {17'd0, o_adr}, 0);
    check("rstSubadr", {29'd0, o_subadr}, 0);
    check("rstPush", {31'd0, o_outFifoWrite}, 0);
    check("rstInactNext", {31'd0, o_CopyInactiveNextCycle}, 0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    // one full aligned block
    expAdr.push_back(15'd0);
    for (int i = 0; i < 8; i++) expData.push_back({16'(2 * i + 1), 16'(2 * i)});
    start(0, 0, 16, 1);
    waitDone();
    // horizontal and vertical wrap
    foreach (t2a[i]) expAdr.push_back(t2a[i]);
    foreach (t2d[i]) expData.push_back(t2d[i]);
    start(1020, 511, 8, 2);
    waitDone();
    // odd pixel count needs a pad push
    expAdr.push_back(15'd0);
    expData.push_back(32'h00010000);
    expData.push_back(32'h00000002);
    start(0, 0, 3, 1);
    waitDone();
    // memory busy holds the request steady
    i_busy = 1'b1;
    modelPush(40, 7, 16, 1);
    start(40, 7, 16, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      check("busyCommand", {31'd0, o_command}, 1);
      check("busyAdr", {17'd0, o_adr}, 32'd450);
    end
    @(posedge i_clk);
    #1 i_busy = 1'b0;
    waitDone();
    // output FIFO full mid-stream
    memLat = 3;
    modelPush(5, 3, 32, 2);
    snap = pushCnt;
    start(5, 3, 32, 2);
    for (int n = 0; n < 200 && pushCnt < snap + 2; n++) @(posedge i_clk);
    #1 i_outFifoFull = 1'b1;
    repeat (5) @(posedge i_clk);
    #1 i_outFifoFull = 1'b0;
    waitDone();
    // reset while waiting for read data aborts the copy
    memLat = 20;
    expAdr.push_back(15'd0);
    start(0, 0, 16, 1);
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b1;
    snap = pushCnt;
    @(negedge i_clk);
    check("abortActive", {31'd0, o_active}, 0);
    check("abortCommand", {31'd0, o_command}, 0);
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    repeat (30) @(posedge i_clk);
    #1;
    check("abortNoPush", pushCnt, snap);
    check("abortAdrConsumed", expAdr.size(), 0);
    inactCnt = 0;
    // normal copy after the abort
    memLat = 1;
    modelPush(100, 200, 20, 3);
    start(100, 200, 20, 3);
    waitDone();
    // long row with an immediate memory
    memLat = 0;
    modelPush(0, 10, 64, 1);
    firstPush = -1;
    start(0, 10, 64, 1);
    waitDone();
`ifdef GPU_COPYVC_PREFETCH_EN
    check("prefetchNoGap", lastPush - firstPush, 62);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
